trng_collector: RTL

Post-processing stage directly downstream of the three-ring RO entropy source. It drives the source's enable chain and samples its `rnd` bit at a programmable rate. It applies von Neumann debiasing and a repetition-count health test to the raw samples, then packs the debiased bits into words. Each word is offered on a valid/ready interface to the consumer (FIFO or bus register).

---
 rtl/trng_pkg.sv | 19 +
 rtl/trng_collector_vn_debias.sv | 37 +++
 rtl/trng_collector.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and default parameters for the RO entropy post-processing path.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_WARMUP,
        ST_COLLECT,
        ST_HOLD,
        ST_FAIL
    } trng_state_t;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_SAMPLE_DIV = 4;
    localparam int DEF_WARMUP_CYC = 16;
    localparam int DEF_REP_LIMIT  = 32;
    localparam int REP_W          = 8;

endpackage

// File: rtl/trng_collector_vn_debias.sv
// Von Neumann debiaser: pairs consecutive strobed samples, emits the first bit of
// every unequal pair and drops equal pairs.
module vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_stb,
    input  logic i_bit,
    output logic o_accept,
    output logic o_bit
);

    logic r_phase;
    logic r_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= 1'b0;
            r_a     <= 1'b0;
        end else if (i_clr) begin
            r_phase <= 1'b0;
            r_a     <= 1'b0;
        end else if (i_stb) begin
            if (!r_phase) begin
                r_a <= i_bit;
            end
            r_phase <= ~r_phase;
        end
    end

    // Accept is combinational on the second strobe so the word fills in the same cycle.
    assign o_accept = i_stb && r_phase && (r_a != i_bit);
    assign o_bit    = r_a;

endmodule

// File: rtl/trng_collector.sv
// Drives the RO enable chain, samples its output at a divided rate, debiases,
// runs a repetition-count health test and offers packed words on valid/ready.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int WARMUP_CYC = DEF_WARMUP_CYC,
    parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    output logic              enable_o,
    input  logic              ro_ready_i,
    input  logic              rnd_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              health_fail_o
);

    localparam int CNT_W  = $clog2(WORD_W + 1);
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

    trng_state_t       r_state;
    trng_state_t       w_state_next;
    logic [DIV_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic [WARM_W-1:0] r_warm;
    logic [REP_W-1:0]  r_rep;
    logic [REP_W-1:0]  w_rep_next;
    logic              r_prev;
    logic              r_seen;
    logic [WORD_W-1:0] r_word;
    logic              w_tick;
    logic              w_accept;
    logic              w_vn_bit;
    logic              w_word_done;
    logic              w_rep_hit;
    logic              w_warm_done;

    assign w_tick      = (r_state == ST_COLLECT) && (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign w_word_done = w_accept && (r_cnt == CNT_W'(WORD_W - 1));
    assign w_warm_done = (r_warm == WARM_W'(WARMUP_CYC - 1));
    assign w_rep_hit   = w_tick && (w_rep_next >= REP_W'(REP_LIMIT));

    always_comb begin
        w_rep_next = r_rep;
        if (!r_seen || (rnd_i != r_prev)) begin
            w_rep_next = REP_W'(1);
        end else if (r_rep != {REP_W{1'b1}}) begin
            w_rep_next = r_rep + REP_W'(1);
        end
    end

    // Pairing restarts whenever we are not actively collecting (warmup exit, HOLD, aborts).
    vn_debias u_vn (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state != ST_COLLECT),
        .i_stb    (w_tick),
        .i_bit    (rnd_i),
        .o_accept (w_accept),
        .o_bit    (w_vn_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_warm  <= '0;
            r_rep   <= '0;
            r_prev  <= 1'b0;
            r_seen  <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == ST_WARMUP) begin
                r_warm <= r_warm + WARM_W'(1);
            end else begin
                r_warm <= '0;
            end

            if ((r_state != ST_COLLECT) || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (r_state != ST_COLLECT) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // The repetition run spans word boundaries; it restarts only on a fresh start.
            if (r_state inside {ST_IDLE, ST_WAIT_RDY, ST_WARMUP}) begin
                r_rep  <= '0;
                r_seen <= 1'b0;
            end else if (w_tick) begin
                r_rep  <= w_rep_next;
                r_prev <= rnd_i;
                r_seen <= 1'b1;
            end

            if (w_accept) begin
                r_word <= {r_word[WORD_W-2:0], w_vn_bit};
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        enable_o      = 1'b0;
        valid_o       = 1'b0;
        health_fail_o = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (run_i) w_state_next = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                enable_o = 1'b1;
                if (!run_i)          w_state_next = ST_IDLE;
                else if (ro_ready_i) w_state_next = ST_WARMUP;
            end
            ST_WARMUP: begin
                enable_o = 1'b1;
                if (!run_i)           w_state_next = ST_IDLE;
                else if (w_warm_done) w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                enable_o = 1'b1;
                if (w_rep_hit)        w_state_next = ST_FAIL;
                else if (!run_i)      w_state_next = ST_IDLE;
                else if (w_word_done) w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                enable_o = 1'b1;
                valid_o  = 1'b1;
                if (ready_i) w_state_next = run_i ? ST_COLLECT : ST_IDLE;
            end
            ST_FAIL: begin
                health_fail_o = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign data_o = r_word;

endmodule
